// File: rtl/serial_adder_if.sv
// serial_adder_if: request/operand inputs and result outputs of the bit-serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             i_start;
    logic             i_sub;
    logic             i_cin;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    modport master (
        output i_start, i_sub, i_cin, i_a, i_b,
        input  o_busy, o_done, o_sum, o_cout, o_ovf
    );
    modport slave (
        input  i_start, i_sub, i_cin, i_a, i_b,
        output o_busy, o_done, o_sum, o_cout, o_ovf
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add/subtract through a single full-adder stage.
module serial_adder #(parameter int WIDTH = 8) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [WIDTH-2:0] r_res;
    logic [CW-1:0]    r_count;
    logic             r_carry, r_cout, r_ovf;
    logic             w_s, w_c, w_last, w_load;
    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = r_count == CW'(WIDTH - 1);
    assign w_load = r_state == IDLE && bus.i_start;
    always_comb begin
        w_next = (r_state == IDLE)  ? (bus.i_start ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Subtract is A + ~B + 1; the partial result fills from the MSB side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_sub ? 1'b1 : bus.i_cin;
            r_count <= '0;
        end else if (r_state == SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= (WIDTH-1)'({w_s, r_res} >> 1);
            r_carry <= w_c;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_res};
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end
    assign bus.o_busy = r_state == SHIFT;
    assign bus.o_done = r_state == DONE;
    assign bus.o_sum  = r_sum;
    assign bus.o_cout = r_cout;
    assign bus.o_ovf  = r_ovf;
endmodule
